// File: rtl/display_scan_if.sv
// Digit-scan bundle between the display driver, the digit-select mux and the board pins.
// The master side is the scan driver. The slave side is the mux and pin environment.
interface display_scan_if;
    logic       en;
    logic [4:0] code;
    logic [2:0] num;
    logic [7:0] an;
    logic [7:0] seg;

    modport master (input en, input code, output num, output an, output seg);
    modport slave  (output en, output code, input num, input an, input seg);
endinterface

// File: rtl/display_scan.sv
// Time-multiplexed seven-segment scan driver. Each digit slot is BLANK_CYC dark cycles
// followed by CLK_DIV lit cycles. Define DISP_LZ_BLANK_EN for leading-zero suppression.
module display_scan #(
    parameter int unsigned NUM_DIGITS = 3,
    parameter int unsigned CLK_DIV    = 50000,
    parameter int unsigned BLANK_CYC  = 16
) (
    input  logic           clk,
    input  logic           rst,
    display_scan_if.master bus
);

    localparam int unsigned CNT_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [2:0]    TOP        = 3'(NUM_DIGITS - 1);

    typedef enum logic {StBlank, StShow} state_e;

    state_e        state;
    logic [CW-1:0] cnt;
    logic [6:0]    digit_seg;

    function automatic logic [6:0] decode(input logic [3:0] hex);
        logic [6:0] s;
        case (hex)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

`ifdef DISP_LZ_BLANK_EN
    // lz stays set while every digit loaded so far in this frame has been zero.
    logic lz;
    logic lz_eff;
    assign lz_eff = lz | (bus.num == TOP);
`endif

    always_comb begin
        digit_seg = decode(bus.code[3:0]);
`ifdef DISP_LZ_BLANK_EN
        if (bus.num != 3'd0 && lz_eff && bus.code[3:0] == 4'h0) begin
            digit_seg = 7'h7F;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StBlank;
            cnt     <= '0;
            bus.num <= TOP;
            bus.an  <= 8'hFF;
            bus.seg <= 8'hFF;
`ifdef DISP_LZ_BLANK_EN
            lz      <= 1'b1;
`endif
        end else begin
            unique case (state)
                StBlank: begin
                    bus.an  <= 8'hFF;
                    bus.seg <= 8'hFF;
                    if (cnt == BLANK_LAST) begin
                        // The only cycle on which code is sampled.
                        bus.seg <= {~bus.code[4], digit_seg};
                        bus.an  <= bus.en ? ~(8'b1 << bus.num) : 8'hFF;
                        cnt     <= '0;
                        state   <= StShow;
`ifdef DISP_LZ_BLANK_EN
                        lz      <= (bus.code[3:0] != 4'h0) ? 1'b0 : lz_eff;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StShow: begin
                    // Disable darkens the digit at once. Re-enable waits for the next load.
                    if (!bus.en) begin
                        bus.an <= 8'hFF;
                    end
                    if (cnt == SHOW_LAST) begin
                        bus.an  <= 8'hFF;
                        bus.seg <= 8'hFF;
                        cnt     <= '0;
                        state   <= StBlank;
                        bus.num <= (bus.num == 3'd0) ? TOP : bus.num - 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= StBlank;
            endcase
        end
    end

endmodule
